// File: rtl/donut_renderer.sv
// donut_renderer
// Per-pixel shader for a torus ring centred on screen. Converts the raster
// position into a visibility flag and a 6-bit luma through a 3-stage pipeline.
// A per-frame animation phase moves a specular band across the ring.

module donut_renderer #(
    parameter int X_CENTER = 305,
    parameter int Y_CENTER = 240,
    parameter int RING_R   = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        frame,
    output logic        donut_visible,
    output logic [5:0]  donut_luma
);

    localparam logic signed [11:0] X_C    = 12'(X_CENTER);
    localparam logic signed [11:0] Y_C    = 12'(Y_CENTER);
    localparam logic signed [12:0] RING_C = 13'(RING_R);

    // Horizontal counter runs at twice the pixel rate, so its LSB carries no position.
    logic unused_h_lsb;
    assign unused_h_lsb = h_count[0];

    // ------------------------------------------------------------------
    // Stage 0 (combinational): centred coordinates and their magnitudes
    // ------------------------------------------------------------------
    logic signed [11:0] x_c;
    logic signed [11:0] y_c;
    logic [10:0]        ax_c;
    logic [10:0]        ay_c;

    assign x_c  = $signed({2'b00, h_count[10:1]}) - X_C;
    assign y_c  = $signed({2'b00, v_count}) - Y_C;
    assign ax_c = x_c[11] ? 11'(-x_c) : 11'(x_c);
    assign ay_c = y_c[11] ? 11'(-y_c) : 11'(y_c);

    // Stage 1: capture |x| and |y|
    logic [10:0] ax_q;
    logic [10:0] ay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax_q <= '0;
            ay_q <= '0;
        end else begin
            ax_q <= ax_c;
            ay_q <= ay_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 -> 2 (combinational): octagonal radius estimate and ring offset
    // ------------------------------------------------------------------
    logic [10:0]        mx_c;
    logic [10:0]        mn_c;
    logic [11:0]        r_c;
    logic signed [12:0] t_c;
    logic               vis_c;

    assign mx_c  = (ax_q >= ay_q) ? ax_q : ay_q;
    assign mn_c  = (ax_q >= ay_q) ? ay_q : ax_q;
    assign r_c   = 12'(mx_c) + 12'(mn_c >> 2) + 12'(mn_c >> 3);
    assign t_c   = $signed({1'b0, r_c}) - RING_C;
    assign vis_c = (t_c >= -13'sd63) && (t_c <= 13'sd63);

    // Stage 2: capture ring offset (7 bits suffice whenever the pixel is visible)
    logic signed [6:0] t_q;
    logic              vis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q   <= '0;
            vis_q <= 1'b0;
        end else begin
            t_q   <= t_c[6:0];
            vis_q <= vis_c;
        end
    end

    // ------------------------------------------------------------------
    // Animation phase: bump once on every edge of the frame LSB
    // ------------------------------------------------------------------
    logic       frame_q;
    logic [7:0] phase;

    // Detect either edge of frame and advance the 8-bit phase, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 1'b0;
            phase   <= '0;
        end else begin
            frame_q <= frame;
            if (frame != frame_q) begin
                phase <= phase + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 -> 3 (combinational): highlight position and quadratic falloff
    // ------------------------------------------------------------------
    logic [6:0]        p_c;
    logic [6:0]        tri_c;
    logic signed [7:0] s_c;
    logic signed [8:0] d_c;
    logic [7:0]        ad_c;
    logic [15:0]       sq_c;
    logic [9:0]        q_c;
    logic [5:0]        luma_c;

    // Triangle wave over the phase keeps the band sweeping back and forth
    // without a jump at either wrap point.
    assign p_c    = phase[6:0];
    assign tri_c  = phase[7] ? (7'd127 - p_c) : p_c;
    assign s_c    = $signed({1'b0, tri_c}) - 8'sd64;
    assign d_c    = {{2{t_q[6]}}, t_q} - {s_c[7], s_c};
    assign ad_c   = d_c[8] ? 8'(-d_c) : 8'(d_c);
    assign sq_c   = 16'(ad_c) * 16'(ad_c);
    assign q_c    = 10'(sq_c >> 6);
    assign luma_c = (q_c > 10'd63) ? 6'd0 : (6'd63 - q_c[5:0]);

    // Stage 3: registered outputs, luma forced to zero off the ring
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            donut_visible <= 1'b0;
            donut_luma    <= '0;
        end else begin
            donut_visible <= vis_q;
            donut_luma    <= vis_q ? luma_c : 6'd0;
        end
    end

endmodule

// File: tb/tb_donut_renderer.sv
// tb_donut_renderer
// Self-checking bench for donut_renderer: directed vector table, multi-cycle
// corner sequences and a randomized run against a behavioural model.

module tb_donut_renderer;

    logic        clk;
    logic        rst_n;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        frame;
    logic        donut_visible;
    logic [5:0]  donut_luma;

    int n_checks;
    int n_fail;
    int ph_total;
    logic mframe_q;

    donut_renderer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .h_count       (h_count),
        .v_count       (v_count),
        .frame         (frame),
        .donut_visible (donut_visible),
        .donut_luma    (donut_luma)
    );

    // 48 MHz-ish pixel clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int    ph;
        int    h;
        int    v;
        int    vis;
        int    luma;
        string name;
    } vec_t;

    localparam int NVEC = 18;
    localparam int NRAND = 400;

    vec_t vecs[NVEC];
    int   rh[NRAND];
    int   rv[NRAND];
    int   rph[NRAND];

    // Behavioural reference: straight arithmetic on the shading rules
    function automatic void model(input int h, input int v, input int ph_cnt,
                                  output int vis, output int luma);
        int x, y, ax, ay, mx, mn, r, t, ph, p, tr, s, d, q;
        x  = (h / 2) - 305;
        y  = v - 240;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        mx = (ax > ay) ? ax : ay;
        mn = (ax > ay) ? ay : ax;
        r  = mx + mn / 4 + mn / 8;
        t  = r - 128;
        vis = (t >= -63 && t <= 63) ? 1 : 0;
        ph = ph_cnt % 256;
        p  = ph % 128;
        tr = (ph >= 128) ? 127 - p : p;
        s  = tr - 64;
        d  = t - s;
        q  = (d * d) / 64;
        luma = (vis == 1 && q <= 63) ? 63 - q : 0;
    endfunction

    task automatic checkOutput(input string name, input int exp_vis, input int exp_luma);
        n_checks++;
        if (donut_visible !== 1'(exp_vis) || donut_luma !== 6'(exp_luma)) begin
            n_fail++;
            $display("[TB] FAIL %s: got visible=%0b luma=%0d, expected visible=%0d luma=%0d",
                     name, donut_visible, donut_luma, exp_vis, exp_luma);
        end
    endtask

    // Drive one pixel position and hold it until it has crossed the pipeline
    task automatic applyStimulus(input int h, input int v);
        @(negedge clk);
        h_count = 11'(h);
        v_count = 10'(v);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Toggle frame once per clock until the phase count reaches target
    task automatic advancePhase(input int target);
        while (ph_total < target) begin
            @(negedge clk);
            frame = ~frame;
            ph_total++;
        end
        @(negedge clk);
    endtask

    int ev, el;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ph_total = 0;

        vecs[0]  = '{0,   866, 240, 1, 0,  "p0_t0"};
        vecs[1]  = '{0,   810, 240, 1, 43, "p0_tm28"};
        vecs[2]  = '{0,   610, 240, 0, 0,  "p0_centre"};
        vecs[3]  = '{64,  866, 240, 1, 63, "p64_t0"};
        vecs[4]  = '{64,  930, 240, 1, 47, "p64_t32"};
        vecs[5]  = '{64,  992, 240, 1, 1,  "p64_t63"};
        vecs[6]  = '{64,  994, 240, 0, 0,  "p64_t64"};
        vecs[7]  = '{64,  810, 340, 1, 62, "p64_diag"};
        vecs[8]  = '{64,  740, 240, 1, 1,  "p64_tm63"};
        vecs[9]  = '{64,  741, 240, 1, 1,  "p64_tm63_odd"};
        vecs[10] = '{64,  738, 240, 0, 0,  "p64_tm64"};
        vecs[11] = '{64,  610, 49,  1, 1,  "p64_top_t63"};
        vecs[12] = '{64,  610, 48,  0, 0,  "p64_top_t64"};
        vecs[13] = '{127, 992, 240, 1, 63, "p127_t63"};
        vecs[14] = '{128, 992, 240, 1, 63, "p128_t63"};
        vecs[15] = '{200, 866, 240, 1, 62, "p200_t0"};
        vecs[16] = '{256, 866, 240, 1, 0,  "wrap_t0"};
        vecs[17] = '{256, 810, 240, 1, 43, "wrap_tm28"};

        // Power-on reset
        rst_n   = 1'b0;
        frame   = 1'b0;
        h_count = 11'd866;
        v_count = 10'd240;
        #1;
        checkOutput("reset_state", 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            advancePhase(vecs[i].ph);
            applyStimulus(vecs[i].h, vecs[i].v);
            checkOutput(vecs[i].name, vecs[i].vis, vecs[i].luma);
        end

        // Two toggles in consecutive cycles advance the phase by two
        @(negedge clk);
        frame = ~frame;
        @(negedge clk);
        frame = ~frame;
        ph_total += 2;
        applyStimulus(866, 240);
        checkOutput("double_toggle", 1, 3);

        // Latency: one pixel per clock, each result appears exactly 3 clocks later
        begin
            int lh[8];
            lh = '{610, 864, 865, 866, 867, 868, 610, 610};
            @(negedge clk);
            h_count = 11'd610;
            v_count = 10'd240;
            repeat (3) @(posedge clk);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                h_count = 11'(lh[k]);
                @(posedge clk);
                #1;
                if (k >= 2) begin
                    model(lh[k-2], 240, ph_total, ev, el);
                    checkOutput($sformatf("latency[%0d]", k - 2), ev, el);
                end
            end
        end

        // Randomized pixels with occasional frame toggles
        mframe_q = frame;
        for (int k = 0; k < NRAND; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                rh[k] = int'($urandom_range(560, 1060));
                rv[k] = int'($urandom_range(60, 420));
            end else begin
                rh[k] = int'($urandom_range(0, 1524));
                rv[k] = int'($urandom_range(0, 524));
            end
            h_count = 11'(rh[k]);
            v_count = 10'(rv[k]);
            if ($urandom_range(0, 7) == 0) begin
                frame = ~frame;
            end
            if (frame != mframe_q) begin
                ph_total++;
            end
            mframe_q = frame;
            rph[k] = ph_total;
            @(posedge clk);
            #1;
            if (k >= 2) begin
                model(rh[k-2], rv[k-2], rph[k-1], ev, el);
                checkOutput($sformatf("rand[%0d]", k - 2), ev, el);
            end
        end

        // Mid-line asynchronous reset, release with frame low
        applyStimulus(810, 240);
        model(810, 240, ph_total, ev, el);
        checkOutput("pre_reset", ev, el);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0);
        frame = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        ph_total = 0;
        @(posedge clk);
        #1;
        checkOutput("release_clk1", 0, 0);
        @(posedge clk);
        #1;
        checkOutput("release_clk2", 0, 0);
        @(posedge clk);
        #1;
        checkOutput("release_clk3", 1, 43);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("phase_held_zero", 1, 43);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
